// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipeline stages.
// Contents: draw-mode encodings, the default active-area size and the
// default palette of the grid background stage.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_SOLID  = 2'd0,   // cells filled, no grid lines
      MODE_BORDER = 2'd1,   // outer frame only, interiors left dark
      MODE_GRID   = 2'd2,   // solid grid lines
      MODE_DOT    = 2'd3    // grid lines drawn every fourth pixel
   } mode_e;

   localparam int DEF_H_ACTIVE = 1024;
   localparam int DEF_V_ACTIVE = 768;

   localparam logic [11:0] DEF_C_BORDER = 12'hff0;
   localparam logic [11:0] DEF_C_GRID   = 12'h44f;
   localparam logic [11:0] DEF_C_FILL   = 12'h888;
   localparam logic [11:0] DEF_C_HILITE = 12'h262;
   localparam logic [11:0] DEF_C_MARGIN = 12'h000;

endpackage

// File: rtl/grid_axis_counter.sv
// Position-within-cell counter for one screen axis.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : holds both counts at 0 (blanking on this axis)
//   i_advance    : step one pixel/line along the axis
//   o_pix        : offset inside the current cell, 0..CELL-1
//   o_cell       : cell index, saturates at CELLS (= margin region)
module grid_axis_counter #(
   parameter int CELL  = 78,
   parameter int CELLS = 13
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_advance,
   output logic [11:0] o_pix,
   output logic [11:0] o_cell
);

   localparam logic [11:0] L_LAST  = 12'(CELL - 1);
   localparam logic [11:0] L_CELLS = 12'(CELLS);

   logic [11:0] r_pix;
   logic [11:0] r_cell;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pix  <= '0;
         r_cell <= '0;
      end else if (i_clear) begin
         r_pix  <= '0;
         r_cell <= '0;
      end else if (i_advance && (r_cell != L_CELLS)) begin
         // Once the margin index is reached the counter freezes until cleared.
         if (r_pix == L_LAST) begin
            r_pix  <= '0;
            r_cell <= r_cell + 12'd1;
         end else begin
            r_pix <= r_pix + 12'd1;
         end
      end
   end

   assign o_pix  = r_pix;
   assign o_cell = r_cell;

endmodule

// File: rtl/draw_grid_background.sv
// Background stage of the VGA pipeline: draws a framed COLS x ROWS graticule
// (one column per channel) with selectable draw mode and an optional
// highlighted column. Two-cycle pipeline: stage 1 registers timing, cell
// position and flags; stage 2 registers the colour and the timing again.
// Ports:
//   pclk, rst                : pixel clock, asynchronous active-high reset
//   mode_in, sel_ch_in       : draw mode / highlighted column, latched at vblank start
//   {v,h}{count,sync,blnk}_in: timing from the generator
//   {v,h}{count,sync,blnk}_out: same timing delayed by 2 pclk
//   rgb_out                  : pixel colour aligned to the delayed timing
module draw_grid_background
   import vga_pkg::*;
#(
   parameter int          H_ACTIVE = DEF_H_ACTIVE,
   parameter int          V_ACTIVE = DEF_V_ACTIVE,
   parameter int          COLS     = 13,
   parameter int          ROWS     = 8,
   parameter logic [11:0] C_BORDER = DEF_C_BORDER,
   parameter logic [11:0] C_GRID   = DEF_C_GRID,
   parameter logic [11:0] C_FILL   = DEF_C_FILL,
   parameter logic [11:0] C_HILITE = DEF_C_HILITE,
   parameter logic [11:0] C_MARGIN = DEF_C_MARGIN
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [1:0]  mode_in,
   input  logic [3:0]  sel_ch_in,
   input  logic [11:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   output logic [11:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out
);

   localparam int          CELL_W     = H_ACTIVE / COLS;
   localparam int          CELL_H     = V_ACTIVE / ROWS;
   localparam logic [11:0] L_H_ACTIVE = 12'(H_ACTIVE);
   localparam logic [11:0] L_V_ACTIVE = 12'(V_ACTIVE);
   localparam logic [11:0] L_H_LAST   = 12'(H_ACTIVE - 1);
   localparam logic [11:0] L_V_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [11:0] L_COLS     = 12'(COLS);
   localparam logic [11:0] L_ROWS     = 12'(ROWS);

   // Frame latch and edge detectors
   mode_e       r_mode;
   logic [3:0]  r_sel;
   logic        r_prev_hblnk;
   logic        r_prev_vblnk;

   // Counter outputs
   logic [11:0] w_h_pix, w_h_col, w_v_pix, w_v_row;

   // Stage 1
   logic [11:0] r1_vcount, r1_hcount;
   logic        r1_vsync, r1_vblnk, r1_hsync, r1_hblnk;
   logic [11:0] r1_h_pix, r1_h_col, r1_v_pix, r1_v_row;
   logic        r1_active;   // reset value 0 makes the first post-reset pixel black
   logic        r1_frame;
   logic        r1_oor;

   // Stage 2 colour
   logic        w_grid_hit;
   logic        w_hilite;
   logic [11:0] w_rgb;

   grid_axis_counter #(.CELL(CELL_W), .CELLS(COLS)) u_h_cnt (
      .i_clk     (pclk),
      .i_rst     (rst),
      .i_clear   (hblnk_in),
      .i_advance (!hblnk_in),
      .o_pix     (w_h_pix),
      .o_cell    (w_h_col)
   );

   // Lines advance on the start of horizontal blanking.
   grid_axis_counter #(.CELL(CELL_H), .CELLS(ROWS)) u_v_cnt (
      .i_clk     (pclk),
      .i_rst     (rst),
      .i_clear   (vblnk_in),
      .i_advance (hblnk_in && !r_prev_hblnk),
      .o_pix     (w_v_pix),
      .o_cell    (w_v_row)
   );

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_mode       <= MODE_GRID;
         r_sel        <= 4'hf;
         r_prev_hblnk <= 1'b0;
         r_prev_vblnk <= 1'b0;
      end else begin
         r_prev_hblnk <= hblnk_in;
         r_prev_vblnk <= vblnk_in;
         // Sampling only at vblank start keeps a frame visually consistent.
         if (vblnk_in && !r_prev_vblnk) begin
            r_mode <= mode_e'(mode_in);
            r_sel  <= sel_ch_in;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r1_vcount <= '0;
         r1_vsync  <= 1'b0;
         r1_vblnk  <= 1'b0;
         r1_hcount <= '0;
         r1_hsync  <= 1'b0;
         r1_hblnk  <= 1'b0;
         r1_h_pix  <= '0;
         r1_h_col  <= '0;
         r1_v_pix  <= '0;
         r1_v_row  <= '0;
         r1_active <= 1'b0;
         r1_frame  <= 1'b0;
         r1_oor    <= 1'b0;
      end else begin
         r1_vcount <= vcount_in;
         r1_vsync  <= vsync_in;
         r1_vblnk  <= vblnk_in;
         r1_hcount <= hcount_in;
         r1_hsync  <= hsync_in;
         r1_hblnk  <= hblnk_in;
         r1_h_pix  <= w_h_pix;
         r1_h_col  <= w_h_col;
         r1_v_pix  <= w_v_pix;
         r1_v_row  <= w_v_row;
         r1_active <= !hblnk_in && !vblnk_in;
         r1_frame  <= (hcount_in == 12'd0) || (hcount_in == L_H_LAST) ||
                      (vcount_in == 12'd0) || (vcount_in == L_V_LAST);
         r1_oor    <= (hcount_in >= L_H_ACTIVE) || (vcount_in >= L_V_ACTIVE);
      end
   end

   // Dotted mode keeps a grid pixel only every fourth step along the line.
   always_comb begin
      w_grid_hit = 1'b0;
      if (r_mode == MODE_GRID) begin
         w_grid_hit = (r1_h_pix == 12'd0) || (r1_v_pix == 12'd0);
      end else if (r_mode == MODE_DOT) begin
         w_grid_hit = ((r1_h_pix == 12'd0) && (r1_vcount[1:0] == 2'd0)) ||
                      ((r1_v_pix == 12'd0) && (r1_hcount[1:0] == 2'd0));
      end
   end

   assign w_hilite = (r_mode != MODE_SOLID) && ({8'd0, r_sel} < L_COLS) &&
                     (r1_h_col == {8'd0, r_sel});

   always_comb begin
      w_rgb = C_MARGIN;
      if (!r1_active)                                     w_rgb = 12'h000;
      else if (r1_frame)                                  w_rgb = C_BORDER;
      else if (r1_oor || (r1_h_col == L_COLS) ||
               (r1_v_row == L_ROWS))                      w_rgb = C_MARGIN;
      else if (w_grid_hit)                                w_rgb = C_GRID;
      else if (w_hilite)                                  w_rgb = C_HILITE;
      else if (r_mode == MODE_BORDER)                     w_rgb = C_MARGIN;
      else                                                w_rgb = C_FILL;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vcount_out <= '0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hcount_out <= '0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         vcount_out <= r1_vcount;
         vsync_out  <= r1_vsync;
         vblnk_out  <= r1_vblnk;
         hcount_out <= r1_hcount;
         hsync_out  <= r1_hsync;
         hblnk_out  <= r1_hblnk;
         rgb_out    <= w_rgb;
      end
   end

endmodule

// File: tb/tb_draw_grid_background.sv
module tb_draw_grid_background;

  localparam logic [11:0] C_BORDER = 12'hff0;
  localparam logic [11:0] C_GRID   = 12'h44f;
  localparam logic [11:0] C_FILL   = 12'h888;
  localparam logic [11:0] C_HILITE = 12'h262;
  localparam logic [11:0] C_MARGIN = 12'h000;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [1:0]  mode_in = 2'd0;
  logic [3:0]  sel_ch_in = 4'd0;
  logic [11:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] vcount_out, hcount_out, rgb_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  bit   full_line[768];
  int   chg_line, chg_mode, chg_sel;
  int   m_mode, m_sel;
  bit   m_prev_vb;

  draw_grid_background dut (
    .pclk(pclk), .rst(rst), .mode_in(mode_in), .sel_ch_in(sel_ch_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  // clock
  always #5 pclk = ~pclk;

  function automatic logic [39:0] out_bundle();
    return {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out, rgb_out};
  endfunction

  // Reference picture computed directly from screen coordinates.
  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, int mode, int sel);
    int col, row, hp, vp;
    if (hb || vb) return 12'h000;
    if (h == 0 || h == 1023 || v == 0 || v == 767) return C_BORDER;
    if (h >= 1024 || v >= 768) return C_MARGIN;
    col = h / 78;
    row = v / 96;
    hp  = h % 78;
    vp  = v % 96;
    if (col >= 13 || row >= 8) return C_MARGIN;
    if (mode == 2 && (hp == 0 || vp == 0)) return C_GRID;
    if (mode == 3 && ((hp == 0 && (v % 4) == 0) || (vp == 0 && (h % 4) == 0))) return C_GRID;
    if (mode != 0 && col == sel) return C_HILITE;
    return (mode == 1) ? C_MARGIN : C_FILL;
  endfunction

  // Driver: apply one pixel, record its expected output, check the one due now.
  task automatic tick(input int h, input int v, input bit hs, input bit vs, input bit hb, input bit vb);
    logic [39:0] e;
    logic [39:0] o;
    hcount_in = 12'(h);
    vcount_in = 12'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    if (vb && !m_prev_vb) begin
      m_mode = int'(mode_in);
      m_sel  = int'(sel_ch_in);
    end
    m_prev_vb = vb;
    exp_q.push_back({12'(v), vs, vb, 12'(h), hs, hb, model_rgb(h, v, hb, vb, m_mode, m_sel)});
    @(posedge pclk);
    @(negedge pclk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      o = out_bundle();
      checks++;
      assert (o === e) else begin
        $display("FAIL pix h=%0d v=%0d obs=%h exp=%h", e[25:14], e[39:28], o, e);
        errors++;
        $error("pixel bundle differs");
      end
    end
  endtask

  task automatic run_line(input int v);
    bit full, vb, vs;
    full = (v < 768) && full_line[v];
    vb   = (v >= 768);
    vs   = (v == 770 || v == 771);
    for (int h = 0; h <= (full ? 1023 : 0); h++) tick(h, v, 1'b0, vs, 1'b0, vb);
    if (full && v == 97) begin
      // pixels past the active width but not blanked
      tick(1024, v, 1'b0, vs, 1'b0, vb);
      tick(1025, v, 1'b0, vs, 1'b0, vb);
    end
    for (int h = 1026; h < 1030; h++) tick(h, v, (h == 1027 || h == 1028), vs, 1'b1, vb);
  endtask

  task automatic run_frame();
    for (int v = 0; v < 776; v++) begin
      if (v == chg_line) begin
        mode_in   = 2'(chg_mode);
        sel_ch_in = 4'(chg_sel);
      end
      run_line(v);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert (out_bundle() === 40'h0) else begin
      $display("FAIL %s obs=%h exp=%h", tag, out_bundle(), 40'h0);
      errors++;
      $error("reset value");
    end
  endtask

  initial begin
    // reset, then some free-running garbage
    repeat (2) @(negedge pclk);
    check_zero("rst_initial");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hcount_in = 12'($urandom_range(1, 4095));
      vcount_in = 12'($urandom_range(1, 4095));
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom_range(0, 15));
      mode_in   = 2'($urandom_range(0, 3));
      sel_ch_in = 4'($urandom_range(0, 15));
      @(negedge pclk);
    end
    // asynchronous assertion mid-line, between clock edges
    @(posedge pclk);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      hcount_in = 12'($urandom_range(1, 4095));
      vcount_in = 12'($urandom_range(1, 4095));
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom_range(0, 15));
      @(negedge pclk);
      check_zero("rst_hold");
    end

    // release at the first pixel of a frame; mode_in/sel_ch_in not yet latched
    exp_q.delete();
    exp_q.push_back(40'h0);
    m_mode = 2; m_sel = 15; m_prev_vb = 1'b0;
    mode_in = 2'd3; sel_ch_in = 4'd3;
    rst = 1'b0;

    // frame A: reset mode (grid), no highlight; request border mode mid-frame
    full_line = '{default: 1'b0};
    full_line[0] = 1; full_line[96] = 1; full_line[97] = 1; full_line[300] = 1; full_line[385] = 1;
    chg_line = 300; chg_mode = 1; chg_sel = 3;
    run_frame();

    // frame B: border only, column 3 highlighted
    full_line = '{default: 1'b0};
    full_line[96] = 1; full_line[97] = 1;
    chg_line = 500; chg_mode = 3; chg_sel = 13;
    run_frame();

    // frame C: dotted grid, highlight index out of range
    full_line = '{default: 1'b0};
    full_line[96] = 1; full_line[97] = 1; full_line[100] = 1;
    chg_line = 500; chg_mode = 0; chg_sel = 3;
    run_frame();

    // frame D: solid fill ignores the highlight
    full_line = '{default: 1'b0};
    full_line[97] = 1;
    chg_line = 500; chg_mode = 2; chg_sel = 3;
    run_frame();

    // frame E: full grid with column 3 highlighted
    full_line = '{default: 1'b0};
    full_line[97] = 1; full_line[200] = 1;
    chg_line = -1;
    run_frame();

    tick(1026, 0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
